// File: rtl/j1_wb_pkg.sv
// Shared types and constants for the J1 data-port to Wishbone bridge.
// Holds the bridge FSM encoding, default bus widths and the timeout counter sizing helper.
package j1_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    // Width needed to count up to TIMEOUT; never narrower than one bit.
    function automatic int tmo_width(input int t);
        if (t < 1) return 1;
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: counts cycles while enabled and flags when a cycle has used its budget.
// Latency: expired is combinational from the count, asserted in the TIMEOUT-th enabled cycle.
// Backpressure: none; clr has priority over en, and the count holds once the limit is reached.
module wb_timeout
    import j1_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = tmo_width(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, clr, en};
            assign expired   = 1'b0;
        end else begin : g_on
            // The count starts at 0 in the first enabled cycle, so TIMEOUT-1 marks the last one.
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en && (cnt != LAST)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/j1_wb_master.sv
// Bridges one held J1 data/IO request into a single pipelined Wishbone cycle.
// Latency: 3 cycles to cpu_ack with a registered-ack slave, plus one cycle per stall cycle.
// Backpressure: wb_stall_i holds the strobe; a watchdog or wb_err_i ends hung or faulted cycles.
module j1_wb_master
    import j1_wb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdat,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdat,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i,
    input  logic          wb_err_i
);

    state_t state, state_nxt;
    logic   lat_req;
    logic   fin;
    logic   fin_err;
    logic   tmo_clr;
    logic   tmo_en;
    logic   tmo_exp;
    logic   err_q;

    assign tmo_en = (state == REQ) || (state == WAIT);

    wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion priority: slave error, then ack, then watchdog. Ack/err only count once the
    // strobe has been accepted (stall low).
    always_comb begin
        state_nxt = state;
        lat_req   = 1'b0;
        tmo_clr   = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    lat_req   = 1'b1;
                    tmo_clr   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!wb_stall_i && wb_err_i) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (!wb_stall_i && wb_ack_i) begin
                    fin = 1'b1;
                end else if (tmo_exp) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (!wb_stall_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wb_err_i) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (wb_ack_i) begin
                    fin = 1'b1;
                end else if (tmo_exp) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (fin) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            cpu_rdat <= '0;
            err_q    <= 1'b0;
        end else begin
            if (lat_req) begin
                wb_we_o  <= cpu_we;
                wb_adr_o <= cpu_adr;
                wb_dat_o <= cpu_wdat;
            end
            if (fin) begin
                err_q <= fin_err;
                if (fin_err) begin
                    cpu_rdat <= '0;
                end else if (!wb_we_o) begin
                    cpu_rdat <= wb_dat_i;
                end
            end
        end
    end

    assign wb_cyc_o = (state == REQ) || (state == WAIT);
    assign wb_stb_o = (state == REQ);
    assign cpu_ack  = (state == DONE);
    assign cpu_err  = cpu_ack && err_q;

endmodule

// File: tb/tb_j1_wb_master.sv
// Directed bench for j1_wb_master against a registered-ack RAM slave with stall/error injection.
module tb_j1_wb_master;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_wdat;
    logic        cpu_ack;
    logic        cpu_err;
    logic [15:0] cpu_rdat;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic        wb_err_i;

    logic        mute;
    logic        inj_ack;
    logic        inj_err;
    logic        ram_ack;
    logic [15:0] ram_dat;
    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    j1_wb_master #(
        .AW      (16),
        .DW      (16),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_adr    (cpu_adr),
        .cpu_wdat   (cpu_wdat),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .cpu_rdat   (cpu_rdat),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (wb_stall_i),
        .wb_err_i   (wb_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM slave: ack one cycle after an accepted strobe, silenced by mute.
    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !wb_stall_i && !mute) begin
            ram_ack <= 1'b1;
            ram_dat <= mem[wb_adr_o[7:0]];
            if (wb_we_o) mem[wb_adr_o[7:0]] <= wb_dat_o;
        end else begin
            ram_ack <= 1'b0;
        end
    end

    assign wb_ack_i = ram_ack | inj_ack;
    assign wb_err_i = inj_err;
    assign wb_dat_i = inj_ack ? 16'h5A5A : ram_dat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one CPU request and follow it to cpu_ack. Cycle k is observed at the k-th
    // falling edge after the edge that samples cpu_req.
    task automatic access(input string tag, input logic we, input logic [15:0] adr,
                          input logic [15:0] wdat, input int nstall, input logic mute_i,
                          input int inj_at, input logic inj_a, input logic inj_e,
                          input int exp_lat, input logic exp_err, input logic [15:0] exp_rdat);
        int          lat;
        logic        hold_ok;
        logic        got_err;
        logic [15:0] got_rdat;
        lat      = 0;
        hold_ok  = 1'b1;
        got_err  = 1'b0;
        got_rdat = 16'h0;
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_adr    = adr;
        cpu_wdat   = wdat;
        wb_stall_i = (nstall > 0);
        mute       = mute_i;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            inj_ack = 1'b0;
            inj_err = 1'b0;
            if (k <= nstall + 1 &&
                !(wb_cyc_o && wb_stb_o && wb_adr_o == adr && wb_dat_o == wdat && wb_we_o == we))
                hold_ok = 1'b0;
            if (cpu_ack) begin
                lat      = k;
                got_err  = cpu_err;
                got_rdat = cpu_rdat;
                cpu_req  = 1'b0;
            end
            if (k == nstall + 1) wb_stall_i = 1'b0;
            if (k == inj_at) begin
                inj_ack = inj_a;
                inj_err = inj_e;
            end
        end
        cpu_req = 1'b0;
        inj_ack = 1'b0;
        inj_err = 1'b0;
        check({tag, "_lat"},  lat,      exp_lat);
        check({tag, "_err"},  got_err,  exp_err);
        check({tag, "_rdat"}, got_rdat, exp_rdat);
        check({tag, "_hold"}, hold_ok,  1'b1);
        @(negedge clk);
        check({tag, "_ack1"}, cpu_ack,  1'b0);
    endtask

    initial begin
        int   acks;
        logic rdat_ok;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst_n      = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_adr    = 16'h0;
        cpu_wdat   = 16'h0;
        wb_stall_i = 1'b0;
        mute       = 1'b0;
        inj_ack    = 1'b0;
        inj_err    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl",  {wb_cyc_o, wb_stb_o, wb_we_o, cpu_ack, cpu_err}, 5'b0);
        check("rst_adr",  wb_adr_o, 16'h0);
        check("rst_dat",  wb_dat_o, 16'h0);
        check("rst_rdat", cpu_rdat, 16'h0);
        rst_n = 1'b1;

        // Plain write; rdat stays at its reset value since writes do not load it.
        access("wr", 1'b1, 16'h0012, 16'hBEEF, 0, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0, 16'h0000);
        check("wr_mem", mem[8'h12], 16'hBEEF);

        access("rd", 1'b0, 16'h0012, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0, 16'hBEEF);
        rdat_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cpu_rdat != 16'hBEEF || cpu_ack) rdat_ok = 1'b0;
        end
        check("rd_idle_hold", rdat_ok, 1'b1);

        // Four stall cycles: strobe held for five, ack seven cycles after the request.
        access("stall", 1'b1, 16'h0034, 16'h1234, 4, 1'b0, 0, 1'b0, 1'b0, 7, 1'b0, 16'hBEEF);
        check("stall_mem", mem[8'h34], 16'h1234);

        // Silent slave: watchdog of 8 cycles ends the cycle with an error.
        access("tmo", 1'b0, 16'h0012, 16'h0000, 0, 1'b1, 0, 1'b0, 1'b0, 9, 1'b1, 16'h0000);
        acks = 0;
        @(negedge clk);
        inj_ack = 1'b1;
        acks += int'(cpu_ack);
        @(negedge clk);
        inj_ack = 1'b0;
        repeat (4) begin
            acks += int'(cpu_ack);
            @(negedge clk);
        end
        check("late_ack", acks, 0);

        // Ack in the strobe cycle itself completes straight from REQ.
        access("zlat", 1'b0, 16'h0040, 16'h0000, 0, 1'b1, 1, 1'b1, 1'b0, 2, 1'b0, 16'h5A5A);

        // Ack and error together in WAIT: error wins, data cleared.
        access("serr", 1'b0, 16'h0012, 16'h0000, 0, 1'b1, 2, 1'b1, 1'b1, 3, 1'b1, 16'h0000);

        // Reset in the middle of WAIT drops the cycle without waiting for a clock.
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 16'h0012;
        mute    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arst_pre_cyc", {wb_cyc_o, wb_stb_o}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cyc_drop", {wb_cyc_o, wb_stb_o, cpu_ack}, 3'b000);
        cpu_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            acks += int'(cpu_ack);
        end
        check("arst_no_ack", acks, 0);
        rst_n = 1'b1;

        access("post_rst", 1'b0, 16'h0012, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
